// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace queue: FSM states, record metadata layout
// and the exit code reported when the core stops retiring instructions.
package commit_trace_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALT
    } trace_state_t;

    localparam logic [7:0] HALT_CODE_TIMEOUT = 8'hFF;

    // XLEN-independent part of a commit record; PC and write data sit above it.
    typedef struct packed {
        logic [31:0] instr;
        logic        wen;
        logic [4:0]  wdest;
        logic [31:0] cycle;
    } commit_meta_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; the head entry is read
// combinationally from storage and pops on an empty FIFO are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/commit_trace_queue.sv
// Buffers retired-instruction records for a trace checker and requests the
// end of simulation after a trap or a long stretch without retirements.
module commit_trace_queue
    import commit_trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 5000,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [31:0]     commit_instr,
    input  logic            commit_wen,
    input  logic [4:0]      commit_wdest,
    input  logic [XLEN-1:0] commit_wdata,
    input  logic            trap_valid,
    input  logic [7:0]      trap_code,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            out_wen,
    output logic [4:0]      out_wdest,
    output logic [XLEN-1:0] out_wdata,
    output logic [31:0]     out_cycle,
    output logic [CW-1:0]   count,
    output logic            overflow,
    output logic            halt,
    output logic [7:0]      halt_code
);

    localparam int MW    = $bits(commit_meta_t);
    localparam int REC_W = 2 * XLEN + MW;

    trace_state_t state, next_state;
    logic [31:0]  cycle_cnt;
    logic [31:0]  idle_cnt;
    logic [7:0]   code_q;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop;
    logic         in_run;
    logic         push_ok;
    logic         idle_expire;
    commit_meta_t in_meta;
    commit_meta_t head_meta;
    logic [REC_W-1:0] push_rec;
    logic [REC_W-1:0] head_rec;

    assign in_run      = (state == ST_RUN);
    assign pop         = out_valid && out_ready;
    assign push_ok     = in_run && commit_valid && (!fifo_full || pop);
    assign idle_expire = (idle_cnt == 32'(TIMEOUT - 1)) && !push_ok;

    assign in_meta  = '{instr: commit_instr, wen: commit_wen, wdest: commit_wdest, cycle: cycle_cnt};
    assign push_rec = {commit_pc, commit_wdata, in_meta};

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_ok),
        .pop   (pop),
        .wdata (push_rec),
        .rdata (head_rec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign out_valid = !fifo_empty;
    assign out_pc    = head_rec[REC_W-1 -: XLEN];
    assign out_wdata = head_rec[REC_W-XLEN-1 -: XLEN];
    assign head_meta = commit_meta_t'(head_rec[MW-1:0]);
    assign out_instr = head_meta.instr;
    assign out_wen   = head_meta.wen;
    assign out_wdest = head_meta.wdest;
    assign out_cycle = head_meta.cycle;

    assign halt      = (state == ST_HALT);
    assign halt_code = halt ? code_q : 8'h00;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_RUN;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_RUN:   if (trap_valid || idle_expire) next_state = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) next_state = ST_HALT;
            ST_HALT:  next_state = ST_HALT;
            default:  next_state = ST_RUN;
        endcase
    end

    // A trap in the same cycle as the timeout takes priority for the exit code.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            code_q    <= 8'h00;
            cycle_cnt <= '0;
            idle_cnt  <= '0;
            overflow  <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (in_run && trap_valid)       code_q <= trap_code;
            else if (in_run && idle_expire) code_q <= HALT_CODE_TIMEOUT;
            if (in_run && next_state == ST_RUN) idle_cnt <= push_ok ? '0 : idle_cnt + 1'b1;
            else                                idle_cnt <= '0;
            if (in_run && commit_valid && !push_ok) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_commit_trace_queue.sv
// Self-checking bench: directed vector tables for the corner sequences plus
// randomized traffic compared against a queue-based reference model.
module tb_commit_trace_queue;

    localparam int DEPTH   = 16;
    localparam int XLEN    = 64;
    localparam int TIMEOUT = 8;
    localparam int CW      = $clog2(DEPTH) + 1;

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_HALT  = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            commit_valid = 1'b0;
    logic [XLEN-1:0] commit_pc = '0;
    logic [31:0]     commit_instr = '0;
    logic            commit_wen = 1'b0;
    logic [4:0]      commit_wdest = '0;
    logic [XLEN-1:0] commit_wdata = '0;
    logic            trap_valid = 1'b0;
    logic [7:0]      trap_code = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic            out_wen;
    logic [4:0]      out_wdest;
    logic [XLEN-1:0] out_wdata;
    logic [31:0]     out_cycle;
    logic [CW-1:0]   count;
    logic            overflow;
    logic            halt;
    logic [7:0]      halt_code;

    int checks   = 0;
    int failures = 0;

    commit_trace_queue #(
        .DEPTH   (DEPTH),
        .XLEN    (XLEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_instr (commit_instr),
        .commit_wen   (commit_wen),
        .commit_wdest (commit_wdest),
        .commit_wdata (commit_wdata),
        .trap_valid   (trap_valid),
        .trap_code    (trap_code),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_wen      (out_wen),
        .out_wdest    (out_wdest),
        .out_wdata    (out_wdata),
        .out_cycle    (out_cycle),
        .count        (count),
        .overflow     (overflow),
        .halt         (halt),
        .halt_code    (halt_code)
    );

    always #5 clock = ~clock;

    // Reference model: records held in a queue, state as a plain integer.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        wen;
        logic [4:0]  wdest;
        logic [63:0] wdata;
        logic [31:0] cyc;
    } rec_t;

    rec_t        mq[$];
    int          m_state;
    int          m_idle;
    logic [31:0] m_cycle;
    logic        m_over;
    logic [7:0]  m_code;

    typedef struct {
        bit          cv;
        logic [63:0] pc;
        bit          rdy;
        bit          trap;
        logic [7:0]  code;
        int          exp_count;
        bit          exp_valid;
        logic [63:0] exp_pc;
        bit          exp_halt;
        logic [7:0]  exp_code;
    } vec_t;

    vec_t tab[$];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_state = M_RUN;
        m_idle  = 0;
        m_cycle = '0;
        m_over  = 1'b0;
        m_code  = 8'h00;
    endtask

    task automatic model_update();
        int   pre_size;
        bit   pop_now;
        bit   acc;
        rec_t r;
        pre_size = mq.size();
        pop_now  = (pre_size != 0) && out_ready;
        acc      = 1'b0;
        if (m_state == M_RUN && commit_valid) begin
            acc = (pre_size < DEPTH) || pop_now;
            if (!acc) m_over = 1'b1;
        end
        if (pop_now) void'(mq.pop_front());
        if (acc) begin
            r.pc = commit_pc; r.instr = commit_instr; r.wen = commit_wen;
            r.wdest = commit_wdest; r.wdata = commit_wdata; r.cyc = m_cycle;
            mq.push_back(r);
        end
        if (m_state == M_RUN) begin
            if (trap_valid) begin
                m_state = M_DRAIN; m_code = trap_code; m_idle = 0;
            end else if (!acc && m_idle == TIMEOUT - 1) begin
                m_state = M_DRAIN; m_code = 8'hFF; m_idle = 0;
            end else begin
                m_idle = acc ? 0 : m_idle + 1;
            end
        end else if (m_state == M_DRAIN && pre_size == 0) begin
            m_state = M_HALT;
        end
        m_cycle = m_cycle + 1;
    endtask

    task automatic compare_model();
        check_output("count", 64'(count), 64'(mq.size()));
        check_output("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        check_output("overflow", 64'(overflow), 64'(m_over));
        check_output("halt", 64'(halt), 64'(m_state == M_HALT));
        if (mq.size() != 0) begin
            check_output("out_pc", out_pc, mq[0].pc);
            check_output("out_instr", 64'(out_instr), 64'(mq[0].instr));
            check_output("out_wen", 64'(out_wen), 64'(mq[0].wen));
            check_output("out_wdest", 64'(out_wdest), 64'(mq[0].wdest));
            check_output("out_wdata", out_wdata, mq[0].wdata);
            check_output("out_cycle", 64'(out_cycle), 64'(mq[0].cyc));
        end
        if (m_state == M_HALT) check_output("halt_code", 64'(halt_code), 64'(m_code));
    endtask

    task automatic apply_stimulus(input bit cv, input logic [63:0] pc, input bit rdy,
                                  input bit trap, input logic [7:0] code);
        commit_valid = cv;
        commit_pc    = pc;
        commit_instr = $urandom;
        commit_wen   = 1'($urandom_range(0, 1));
        commit_wdest = 5'($urandom_range(0, 31));
        commit_wdata = {$urandom, $urandom};
        out_ready    = rdy;
        trap_valid   = trap;
        trap_code    = code;
        @(posedge clock);
        model_update();
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        commit_valid = 1'b0;
        out_ready    = 1'b0;
        trap_valid   = 1'b0;
        #1;
        check_output("rst_count", 64'(count), 64'd0);
        check_output("rst_out_valid", 64'(out_valid), 64'd0);
        check_output("rst_overflow", 64'(overflow), 64'd0);
        check_output("rst_halt", 64'(halt), 64'd0);
        check_output("rst_halt_code", 64'(halt_code), 64'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic add_vec(input bit cv, input logic [63:0] pc, input bit rdy, input bit trap,
                           input logic [7:0] code, input int ec, input bit ev,
                           input logic [63:0] epc, input bit eh, input logic [7:0] ecode);
        vec_t v;
        v.cv = cv; v.pc = pc; v.rdy = rdy; v.trap = trap; v.code = code;
        v.exp_count = ec; v.exp_valid = ev; v.exp_pc = epc; v.exp_halt = eh; v.exp_code = ecode;
        tab.push_back(v);
    endtask

    task automatic run_table(input string tag);
        foreach (tab[i]) begin
            apply_stimulus(tab[i].cv, tab[i].pc, tab[i].rdy, tab[i].trap, tab[i].code);
            check_output({tag, "_count"}, 64'(count), 64'(tab[i].exp_count));
            check_output({tag, "_valid"}, 64'(out_valid), 64'(tab[i].exp_valid));
            if (tab[i].exp_valid) check_output({tag, "_pc"}, out_pc, tab[i].exp_pc);
            check_output({tag, "_halt"}, 64'(halt), 64'(tab[i].exp_halt));
            if (tab[i].exp_halt) check_output({tag, "_code"}, 64'(halt_code), 64'(tab[i].exp_code));
        end
        tab.delete();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] base;
        base = 64'h8000_0000;

        // Three back-to-back commits with the checker always ready.
        do_reset();
        add_vec(1, base,      1, 0, 8'h00, 1, 1, base,      0, 8'h00);
        add_vec(1, base + 4,  1, 0, 8'h00, 1, 1, base + 4,  0, 8'h00);
        add_vec(1, base + 8,  1, 0, 8'h00, 1, 1, base + 8,  0, 8'h00);
        add_vec(0, 64'h0,     1, 0, 8'h00, 0, 0, 64'h0,     0, 8'h00);
        run_table("fwft");

        // Fill to DEPTH, drop the 17th, then push while popping at full.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(1, base + 64'(4 * i), 0, 0, 8'h00);
            if (i == 15) check_output("full_no_ovf", 64'(overflow), 64'd0);
        end
        check_output("full_count", 64'(count), 64'd16);
        check_output("full_ovf", 64'(overflow), 64'd1);
        apply_stimulus(1, 64'h1234, 1, 0, 8'h00);
        check_output("full_pushpop_count", 64'(count), 64'd16);
        check_output("full_pushpop_head", out_pc, base + 64'd4);

        // Trap with two entries queued; commits during DRAIN are ignored.
        do_reset();
        add_vec(1, base,     0, 0, 8'h00, 1, 1, base, 0, 8'h00);
        add_vec(1, base + 4, 0, 0, 8'h00, 2, 1, base, 0, 8'h00);
        add_vec(0, 64'h0,    0, 1, 8'h00, 2, 1, base, 0, 8'h00);
        for (int i = 0; i < 5; i++) add_vec(1, 64'h99, 0, 0, 8'h00, 2, 1, base, 0, 8'h00);
        add_vec(1, 64'h99,   1, 0, 8'h00, 1, 1, base + 4, 0, 8'h00);
        add_vec(1, 64'h99,   1, 0, 8'h00, 0, 0, 64'h0,    0, 8'h00);
        add_vec(1, 64'h99,   1, 0, 8'h00, 0, 0, 64'h0,    1, 8'h00);
        run_table("trap");

        // Idle timeout: halt after edge 9, or edge 15 with a commit at edge 6.
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            apply_stimulus(0, 64'h0, 1, 0, 8'h00);
            check_output("tmo_halt", 64'(halt), 64'(i >= 9));
        end
        check_output("tmo_code", 64'(halt_code), 64'hFF);
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            apply_stimulus(i == 6, 64'h40, 1, 0, 8'h00);
            check_output("tmo_delay_halt", 64'(halt), 64'(i >= 15));
        end
        check_output("tmo_delay_code", 64'(halt_code), 64'hFF);

        // Reset while DRAINing five entries, then confirm RUN accepts again.
        do_reset();
        for (int i = 0; i < 5; i++) apply_stimulus(1, base + 64'(i), 0, 0, 8'h00);
        apply_stimulus(0, 64'h0, 0, 1, 8'h3C);
        check_output("drain_count5", 64'(count), 64'd5);
        do_reset();
        apply_stimulus(1, 64'hABC, 0, 0, 8'h00);
        check_output("post_rst_push", 64'(count), 64'd1);
        check_output("post_rst_pc", out_pc, 64'hABC);

        // Randomized traffic against the reference model.
        for (int r = 0; r < 3; r++) begin
            int ready_pct;
            ready_pct = (r == 0) ? 90 : 55;
            do_reset();
            for (int c = 0; c < 300; c++) begin
                apply_stimulus($urandom_range(0, 99) < 80, {$urandom, $urandom},
                               $urandom_range(0, 99) < ready_pct,
                               $urandom_range(0, 249) == 0, 8'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/commit_trace_queue.md
COMMIT_TRACE_QUEUE -- requirements
Module: commit_trace_queue

Interface
REQ-001 Parameter DEPTH, 16, queue entries; power of two, >= 2.
REQ-002 Parameter XLEN, 64, PC/data width.
REQ-003 Parameter TIMEOUT, 5000, idle cycles without an accepted commit before timeout halt.
REQ-004 clock  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserts on level 0 regardless of clock).
REQ-006 commit_valid  input  1  core retires one instruction this cycle.
REQ-007 commit_pc  input  XLEN  retired PC.
REQ-008 commit_instr  input  32  retired instruction word.
REQ-009 commit_wen / commit_wdest / commit_wdata  input  1 / 5 / XLEN  GPR writeback of retired instruction.
REQ-010 trap_valid / trap_code  input  1 / 8  core hit a trap instruction; exit code.
REQ-011 out_valid  output  1  head record available to the checker.
REQ-012 out_ready  input  1  checker consumes head this cycle.
REQ-013 out_pc, out_instr, out_wen, out_wdest, out_wdata, out_cycle  output  XLEN,32,1,5,XLEN,32  head record; out_cycle = cycle stamp at push.
REQ-014 count  output  log2(DEPTH)+1  current occupancy.
REQ-015 overflow  output  1  sticky: a commit was dropped.
REQ-016 halt / halt_code  output  1 / 8  simulation end request and exit code.

Function
REQ-017 Internal 32-bit cycle counter increments every cycle out of reset, wraps modulo 2^32; its value is stored in the record as out_cycle.
REQ-018 Push accepted in RUN when commit_valid && (count<DEPTH || (out_valid && out_ready)).
REQ-019 commit_valid in RUN with queue full and no pop: record dropped, overflow set, held until reset.
REQ-020 First-word fall-through: out_valid = (count!=0); record pushed at edge N visible on out_* after edge N; head fields combinational from storage.
REQ-021 Pop occurs when out_valid && out_ready; out_ready with empty queue has no effect.
REQ-022 Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
REQ-023 FSM states RUN, DRAIN, HALT; reset state RUN.
REQ-024 RUN -> DRAIN on trap_valid; trap_code latched; a commit in the same cycle is pushed per REQ-018.
REQ-025 RUN -> DRAIN when idle counter reaches TIMEOUT-1 without accepted commit; latched code 8'hFF; trap_valid in that cycle wins and latches trap_code.
REQ-026 Idle counter clears on every accepted push and on leaving RUN; counts only in RUN.
REQ-027 DRAIN: commit_valid and trap_valid ignored (no push, no overflow); pops continue; DRAIN -> HALT on the edge where count==0 (entering DRAIN with empty queue gives one DRAIN cycle).
REQ-028 HALT: halt=1, halt_code = latched code; terminal until reset; pops still allowed, inputs ignored.

Reset
REQ-029 On reset low: state RUN, count 0, pointers 0, cycle and idle counters 0, overflow 0, halt 0, halt_code 0, out_valid 0; storage contents need not be reset.
REQ-030 Reset mid-operation discards all queued records and latched codes immediately.

Structure
REQ-031 Shared package commit_trace_pkg holds commit record struct, FSM state enum, HALT_CODE_TIMEOUT=8'hFF.
REQ-032 Storage in one sub-module sync_fifo (parameterised width/depth, FWFT, full/empty/count); FSM, counters, stamping in top.

Verification
REQ-033 Push 3 commits pc=0x80000000,+4,+8, out_ready=1 -> out_valid one cycle after each, records in order, count returns 0.
REQ-034 DEPTH=16, out_ready=0, 17 commits -> count=16, overflow=1 after 17th; then out_ready=1 with push -> accepted, count stays 16.
REQ-035 2 entries queued, trap_valid code 0x00 with out_ready=0 for 5 cycles then 1 -> halt rises the edge after the second pop, halt_code=0x00; commits during DRAIN not queued.
REQ-036 TIMEOUT=8, no commits -> halt=1, halt_code=0xFF; one commit at cycle 5 delays halt by 6 cycles.
REQ-037 reset low while count=5 in DRAIN -> next cycle count=0, halt=0, state RUN, overflow=0.
